// File: rtl/dac_spi_driver.sv
// Serial output stage for the horn audio path: samples DACin on a fixed grid and shifts each
// sample to an MCP4901-class DAC as a 16-bit SPI frame, followed by an LDAC strobe.
module dac_spi_driver #(
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned SAMPLE_DIV = 1250
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [7:0] DACin,
   output logic       dacCS_n,
   output logic       dacSCLK,
   output logic       dacSDI,
   output logic       dacLDAC_n,
   output logic       busy,
   output logic       overrun
);

   localparam int unsigned SampW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int unsigned PhW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   if (CLK_DIV < 1) begin : genBadClkDiv
      $error("CLK_DIV must be at least 1");
   end

   typedef enum logic [2:0] {
      StIdle,
      StShiftLo,
      StShiftHi,
      StCsHold,
      StLatch
   } state_t;

   state_t           state;
   logic [SampW-1:0] sampCnt;
   logic [PhW-1:0]   phase;
   logic [3:0]       bitCnt;
   logic [14:0]      shReg;
   logic             tick;
   logic             phaseEnd;
   logic [15:0]      frameWord;

   // Config nibble: channel A, unbuffered, gain 1x, output active.
   assign frameWord = {4'b0011, DACin, 4'b0000};
   assign tick      = (sampCnt == SampW'(SAMPLE_DIV - 1));
   assign phaseEnd  = (phase == PhW'(CLK_DIV - 1));

   // Free-running sample grid, independent of the frame state.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         sampCnt <= '0;
      end else if (tick) begin
         sampCnt <= '0;
      end else begin
         sampCnt <= sampCnt + 1'b1;
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state     <= StIdle;
         phase     <= '0;
         bitCnt    <= '0;
         shReg     <= '0;
         dacCS_n   <= 1'b1;
         dacSCLK   <= 1'b0;
         dacSDI    <= 1'b0;
         dacLDAC_n <= 1'b1;
         busy      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         // A tick on the LATCH exit edge still counts as busy and is dropped.
         overrun <= tick && (state != StIdle);
         unique case (state)
            StIdle: begin
               if (tick) begin
                  shReg   <= frameWord[14:0];
                  bitCnt  <= 4'd15;
                  phase   <= '0;
                  dacCS_n <= 1'b0;
                  dacSDI  <= frameWord[15];
                  busy    <= 1'b1;
                  state   <= StShiftLo;
               end
            end
            StShiftLo: begin
               if (phaseEnd) begin
                  phase   <= '0;
                  dacSCLK <= 1'b1;
                  state   <= StShiftHi;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            StShiftHi: begin
               if (phaseEnd) begin
                  phase   <= '0;
                  dacSCLK <= 1'b0;
                  if (bitCnt != 4'd0) begin
                     bitCnt <= bitCnt - 4'd1;
                     dacSDI <= shReg[14];
                     shReg  <= {shReg[13:0], 1'b0};
                     state  <= StShiftLo;
                  end else begin
                     dacCS_n <= 1'b1;
                     dacSDI  <= 1'b0;
                     state   <= StCsHold;
                  end
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            StCsHold: begin
               if (phaseEnd) begin
                  phase     <= '0;
                  dacLDAC_n <= 1'b0;
                  state     <= StLatch;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            StLatch: begin
               if (phaseEnd) begin
                  phase     <= '0;
                  dacLDAC_n <= 1'b1;
                  busy      <= 1'b0;
                  state     <= StIdle;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: doc/dac_spi_driver.md
# dac_spi_driver

Serial output stage for the horn's audio path: consumes the 8-bit sample bus that SafetyControls produces on `DACout` and drives an external MCP4901-class SPI DAC. A free-running divider samples the bus at a fixed rate, and each sample is shifted out as a 16-bit SPI frame. LDAC is pulsed after every frame so the analog output updates on a uniform sample grid.

## Interface
- `CLK_DIV`, 4, CLOCK_50 cycles per SCLK half-period; SCLK = 50 MHz / (2·CLK_DIV) = 6.25 MHz by default; must be ≥ 1.
- `SAMPLE_DIV`, 1250, CLOCK_50 cycles per sample (40 kHz default); SAMPLE_DIV ≥ 34·CLK_DIV+1 guarantees no dropped samples.
- `CLOCK_50`  input  1  system clock, 50 MHz, all logic on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `DACin`  input  8  sample from SafetyControls `DACout`; unsigned.
- `dacCS_n`  output  1  SPI chip select, active low.
- `dacSCLK`  output  1  SPI clock, idles low; DAC samples SDI on rising edge.
- `dacSDI`  output  1  SPI data, MSB first.
- `dacLDAC_n`  output  1  DAC latch strobe, active low.
- `busy`  output  1  high from frame start until return to IDLE.
- `overrun`  output  1  one-cycle pulse when a sample tick lands while busy.

## Operation
- Clock and reset: one clock, CLOCK_50; reset is asynchronous and active-high.
- All outputs are registered. Reset values: dacCS_n=1, dacSCLK=0, dacSDI=0, dacLDAC_n=1, busy=0, overrun=0. Reset also clears all counters and forces state IDLE.
- Sample counter `sampCnt` (width $clog2(SAMPLE_DIV)):
  - Counts 0..SAMPLE_DIV-1 and wraps; free-running in every state.
  - The tick is asserted in the cycle where sampCnt == SAMPLE_DIV-1.
- Frame word, 16 bits, captured at the tick edge: {4'b0011, DACin[7:0], 4'b0000}.
  - Config nibble = channel A, unbuffered, gain 1x, active.
  - DACin is ignored outside the capture edge.
- Phase counter: width $clog2(CLK_DIV), counts 0..CLK_DIV-1.
- Bit counter: 4 bits, counts 15 down to 0.
- State machine:
  - IDLE: on tick, load the frame, set CS_n=0, SDI=bit15, busy=1, and go to SHIFT_LO.
  - SHIFT_LO: SCLK=0. After CLK_DIV cycles, set SCLK=1 and go to SHIFT_HI.
  - SHIFT_HI: SCLK=1. After CLK_DIV cycles, set SCLK=0. If bit counter > 0: decrement it, present the next bit on SDI, go to SHIFT_LO. If bit counter = 0: set CS_n=1, SDI=0, go to CS_HOLD.
  - CS_HOLD: after CLK_DIV cycles, set LDAC_n=0 and go to LATCH.
  - LATCH: after CLK_DIV cycles, set LDAC_n=1, busy=0, and go to IDLE.
- SDI changes only at SCLK falling edges or at the frame-start edge, never at a rising edge.
- Tick while not in IDLE: the sample is discarded, overrun pulses high for exactly one cycle, and the frame in progress is unaffected.
- A tick on the same edge LATCH exits is treated as "not in IDLE": that sample is dropped and overrun pulses.
- Reset mid-frame: outputs return to their reset values immediately, with no partial LDAC pulse. The first tick after reset release comes at SAMPLE_DIV cycles.

## Timing
Let T be the rising edge at which the tick is sampled in IDLE.
- Frame start (edge T): CS_n↓, SDI=bit15, busy↑.
- SCLK edges:
  - rising edge k (k = 0..15) at T + (2k+1)·CLK_DIV;
  - falling edge k at T + (2k+2)·CLK_DIV, which also presents bit 14−k on SDI for k ≤ 14.
- Frame end:
  - CS_n↑ at T+32·CLK_DIV (simultaneous with the last SCLK fall);
  - LDAC_n↓ at T+33·CLK_DIV;
  - LDAC_n↑ and busy↓ at T+34·CLK_DIV.
- Defaults: 136 cycles per frame, 1250 cycles between frame starts.
- Sample-to-DAC latency is fixed at 34·CLK_DIV cycles.

## Test plan
- Reset values: assert reset → all outputs equal their reset values. Release reset → first CS_n↓ exactly 1250 cycles later.
- Single frame: DACin=8'hA5 → SDI sampled on 16 SCLK rises = 0011_1010_0101_0000. CS_n low for 128 cycles; LDAC_n low for 4 cycles, starting 4 cycles after CS_n↑; busy high for 136 cycles.
- Back-to-back frames: DACin=8'h00, then 8'hFF before the second tick → frames carry 0x3000 and 0x3FF0. CS_n↓ edges are 1250 cycles apart; no overrun.
- Capture-only: toggle DACin every cycle during a frame → shifted data equals the value at edge T.
- Overrun: CLK_DIV=1, SAMPLE_DIV=20 → every other tick pulses overrun for one cycle, and completed frames remain well-formed (34 cycles each).
- Mid-frame reset: assert reset at T+50 → CS_n=1, SCLK=0, LDAC_n=1 immediately. No LDAC pulse occurs, and the next frame starts 1250 cycles after release.
